// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and slot state type for the 1-to-3 stream demultiplexer
package demux_pkg;
   localparam int W = 8;
   localparam int CNT_W = 8;
   localparam logic [1:0] CH0 = 2'b00;
   localparam logic [1:0] CH1 = 2'b01;
   localparam logic [1:0] CH2 = 2'b10;
   localparam logic [1:0] SEL_ILLEGAL = 2'b11;
   typedef enum logic {EMPTY, FULL} slot_e;
endpackage

// File: rtl/demux_1to3_stream_if.sv
// demux_1to3_stream_if: input stream, three output channels and drop status
interface demux_1to3_stream_if #(
   parameter int W = demux_pkg::W,
   parameter int CNT_W = demux_pkg::CNT_W
);
   logic [W-1:0] in_data;
   logic in_valid;
   logic in_ready;
   logic s0;
   logic s1;
   logic [W-1:0] out0_data;
   logic out0_valid;
   logic out0_ready;
   logic [W-1:0] out1_data;
   logic out1_valid;
   logic out1_ready;
   logic [W-1:0] out2_data;
   logic out2_valid;
   logic out2_ready;
   logic [CNT_W-1:0] drop_cnt;
   logic err;
   modport slave (
      input in_data, in_valid, s0, s1, out0_ready, out1_ready, out2_ready,
      output in_ready, out0_data, out0_valid, out1_data, out1_valid,
      output out2_data, out2_valid, drop_cnt, err
   );
   modport master (
      output in_data, in_valid, s0, s1, out0_ready, out1_ready, out2_ready,
      input in_ready, out0_data, out0_valid, out1_data, out1_valid,
      input out2_data, out2_valid, drop_cnt, err
   );
endinterface

// File: rtl/demux_1to3_stream_slot.sv
// stream_slot: one-entry valid/data holding register; a load may coincide with an unload
module stream_slot import demux_pkg::*; #(
   parameter int DW = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic [DW-1:0] data_i,
   input  logic ready_i,
   output logic valid_o,
   output logic [DW-1:0] data_o
);
   slot_e state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   always_comb begin
      state_d = load_i ? FULL : (ready_i ? EMPTY : state_q);
      data_d = load_i ? data_i : data_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         data_q <= data_d;
      end
   end
   assign valid_o = state_q == FULL;
   assign data_o = data_q;
endmodule

// File: rtl/demux_1to3_stream.sv
// demux_1to3_stream: routes a valid/ready stream to one of three registered channels; illegal selects are dropped and counted
module demux_1to3_stream import demux_pkg::*; #(
   parameter int W = demux_pkg::W,
   parameter int CNT_W = demux_pkg::CNT_W
) (
   input logic clk,
   input logic rst,
   demux_1to3_stream_if.slave bus
);
   logic [1:0] sel;
   logic accept, drop;
   logic [2:0] load, vld, rdy;
   logic [3:0] free;
   logic [W-1:0] dat [3];
   logic err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign sel = {bus.s1, bus.s0};
   assign rdy = {bus.out2_ready, bus.out1_ready, bus.out0_ready};
   // top entry stands for the illegal select, which is always accepted
   assign free = {1'b1, ~vld | rdy};
   assign bus.in_ready = !rst && free[sel];
   assign accept = bus.in_valid && bus.in_ready;
   assign drop = accept && sel == SEL_ILLEGAL;
   assign load = {accept && sel == CH2, accept && sel == CH1, accept && sel == CH0};
   for (genvar c = 0; c < 3; c++) begin : g_slot
      stream_slot #(.DW(W)) u_slot (
         .clk(clk),
         .rst(rst),
         .load_i(load[c]),
         .data_i(bus.in_data),
         .ready_i(rdy[c]),
         .valid_o(vld[c]),
         .data_o(dat[c])
      );
   end
   assign bus.out0_valid = vld[0];
   assign bus.out1_valid = vld[1];
   assign bus.out2_valid = vld[2];
   assign bus.out0_data = dat[0];
   assign bus.out1_data = dat[1];
   assign bus.out2_data = dat[2];
   always_comb begin
      err_d = drop;
      cnt_d = (drop && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end
   assign bus.err = err_q;
   assign bus.drop_cnt = cnt_q;
endmodule

// File: tb/tb_demux_1to3_stream.sv
// tb_demux_1to3_stream: directed stimulus checked against a per-channel occupancy model plus literal expectations
module tb_demux_1to3_stream;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   demux_1to3_stream_if #(.W(8), .CNT_W(8)) bus ();
   demux_1to3_stream_if #(.W(8), .CNT_W(2)) b2 ();
   demux_1to3_stream #(.W(8), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   demux_1to3_stream #(.W(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", n, a, e);
      end
   endtask
   // model: each channel is a one-deep queue; a beat leaves when the consumer is ready
   logic m_v [3];
   logic [7:0] m_d [3];
   logic [7:0] m_cnt;
   logic m_err;
   function automatic logic rd(int c);
      return c == 0 ? bus.out0_ready : c == 1 ? bus.out1_ready : bus.out2_ready;
   endfunction
   function automatic logic ov(int c);
      return c == 0 ? bus.out0_valid : c == 1 ? bus.out1_valid : bus.out2_valid;
   endfunction
   function automatic logic [7:0] od(int c);
      return c == 0 ? bus.out0_data : c == 1 ? bus.out1_data : bus.out2_data;
   endfunction
   function automatic logic exp_ready();
      int s;
      s = {bus.s1, bus.s0};
      if (rst) return 1'b0;
      if (s == 3) return 1'b1;
      return !m_v[s] || rd(s);
   endfunction
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            m_v[c] <= 1'b0;
            m_d[c] <= 8'h00;
         end
         m_cnt <= 8'h00;
         m_err <= 1'b0;
      end else begin
         int s;
         s = {bus.s1, bus.s0};
         m_err <= 1'b0;
         for (int c = 0; c < 3; c++) if (m_v[c] && rd(c)) m_v[c] <= 1'b0;
         if (bus.in_valid && exp_ready()) begin
            if (s == 3) begin
               m_err <= 1'b1;
               m_cnt <= (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
            end else begin
               m_v[s] <= 1'b1;
               m_d[s] <= bus.in_data;
            end
         end
      end
   end
   always @(negedge clk) begin
      if (bus.err) err_seen++;
      chk("in_ready", bus.in_ready, exp_ready());
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("out%0d_valid", c), ov(c), m_v[c]);
         if (m_v[c]) chk($sformatf("out%0d_data", c), od(c), m_d[c]);
      end
      chk("drop_cnt", bus.drop_cnt, m_cnt);
      chk("err", bus.err, m_err);
   end
   task automatic send(input logic [7:0] d, input logic [1:0] s, output int n);
      logic r;
      r = 1'b0;
      n = 0;
      bus.in_data = d;
      {bus.s1, bus.s0} = s;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         r = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
         if (r) break;
      end
      chk("send_accept", r, 1'b1);
   endtask
   task automatic idle();
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      int n, e0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      {bus.s1, bus.s0} = 2'b00;
      {bus.out2_ready, bus.out1_ready, bus.out0_ready} = 3'b111;
      b2.in_valid = 1'b0;
      b2.in_data = 8'h00;
      {b2.s1, b2.s0} = 2'b11;
      {b2.out2_ready, b2.out1_ready, b2.out0_ready} = 3'b111;
      #1;
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_out0_valid", bus.out0_valid, 1'b0);
      chk("rst_drop_cnt", bus.drop_cnt, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      // routing
      send(8'h01, 2'b00, n);
      chk("route0_valid", bus.out0_valid, 1'b1);
      chk("route0_data", bus.out0_data, 8'h01);
      send(8'h02, 2'b01, n);
      chk("route0_gone", bus.out0_valid, 1'b0);
      chk("route1_data", bus.out1_data, 8'h02);
      send(8'h03, 2'b10, n);
      chk("route1_gone", bus.out1_valid, 1'b0);
      chk("route2_data", bus.out2_data, 8'h03);
      idle();
      chk("route2_gone", bus.out2_valid, 1'b0);
      // backpressure
      bus.out2_ready = 1'b0;
      send(8'h40, 2'b10, n);
      chk("bp_first", bus.out2_data, 8'h40);
      bus.in_data = 8'h41;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_held", bus.out2_data, 8'h40);
      bus.out2_ready = 1'b1;
      send(8'h41, 2'b10, n);
      chk("bp_wait", n, 1);
      chk("bp_second", bus.out2_data, 8'h41);
      idle();
      chk("bp_drained", bus.out2_valid, 1'b0);
      // throughput
      for (int i = 0; i < 10; i++) begin
         send(8'(i), 2'b00, n);
         chk("tp_cycles", n, 1);
         chk("tp_data", bus.out0_data, i);
      end
      idle();
      // independence
      bus.out0_ready = 1'b0;
      send(8'h55, 2'b00, n);
      send(8'h66, 2'b01, n);
      chk("ind_cycles", n, 1);
      chk("ind_out1", bus.out1_data, 8'h66);
      chk("ind_out0_valid", bus.out0_valid, 1'b1);
      chk("ind_out0_data", bus.out0_data, 8'h55);
      bus.out0_ready = 1'b1;
      idle();
      chk("ind_drained", bus.out0_valid, 1'b0);
      // illegal select
      e0 = err_seen;
      for (int i = 0; i < 3; i++) begin
         send(8'hAA, 2'b11, n);
         chk("ill_cycles", n, 1);
      end
      idle();
      chk("ill_err_pulses", err_seen - e0, 3);
      chk("ill_drop_cnt", bus.drop_cnt, 8'h03);
      // saturation on the narrow counter
      b2.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("sat_in_ready", b2.in_ready, 1'b1);
         @(posedge clk);
         #1;
         chk("sat_cnt", b2.drop_cnt, (i < 2) ? i + 1 : 3);
         chk("sat_err", b2.err, 1'b1);
      end
      b2.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("sat_err_end", b2.err, 1'b0);
      chk("sat_hold", b2.drop_cnt, 2'd3);
      // reset mid-operation
      bus.out1_ready = 1'b0;
      send(8'hA5, 2'b01, n);
      idle();
      chk("mid_full", bus.out1_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", bus.out1_valid, 1'b0);
      chk("mid_rst_cnt", bus.drop_cnt, 8'h00);
      chk("mid_rst_ready", bus.in_ready, 1'b0);
      bus.out1_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      send(8'h11, 2'b00, n);
      chk("post_rst_valid", bus.out0_valid, 1'b1);
      chk("post_rst_data", bus.out0_data, 8'h11);
      idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/demux_1to3_stream.md
Name: demux_1to3_stream

Overview:
- Registered 1-to-3 stream demultiplexer, the counterpart of the 3-to-1 selector.
- Routes one valid/ready input stream to one of three output channels, chosen per beat by select bits s1:s0.
- Each output channel has a one-entry holding register, so a stalled channel does not lose data.
- Beats with an illegal select are consumed, dropped and counted.

Parameters:
- W, 8, data width of the input and each output channel.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  W  input beat data.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- s0  input  1  select LSB, sampled with the beat.
- s1  input  1  select MSB, sampled with the beat.
- out0_data  output  W  channel 0 data (registered).
- out0_valid  output  1  channel 0 holds a beat.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data, out1_valid, out1_ready: same as channel 0, for channel 1.
- out2_data, out2_valid, out2_ready: same as channel 0, for channel 2.
- drop_cnt  output  CNT_W  count of dropped beats, saturating.
- err  output  1  one-cycle pulse per dropped beat.

Behaviour:
- Clock and reset are fixed: one clock, clk. rst is asynchronous and active-high.
- Reset values: all outN_valid=0, all outN_data=0, drop_cnt=0, err=0. in_ready is combinational and is 0 while rst is high.
- Reset mid-operation: held beats are discarded and no output handshake completes. Operation resumes on the first rising edge of clk after rst deasserts.
- Select map (sel = {s1,s0}):
  - 00 -> channel 0.
  - 01 -> channel 1.
  - 10 -> channel 2.
  - 11 -> illegal.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when outN_valid && outN_ready.
  - in_valid may be held with in_data and sel changing only after a transfer. Behaviour under a mid-beat sel change is undefined, and the bench must not do it.
- Per-channel slot state is EMPTY (valid=0) or FULL (valid=1).
  - EMPTY -> FULL on an input transfer routed to this channel.
  - FULL -> EMPTY on an output transfer with no new routed input.
  - FULL -> FULL (data replaced) on an output transfer and a routed input transfer in the same cycle. This gives full throughput: one beat per cycle per channel.
- in_ready rule, combinational:
  - For sel 00/01/10: in_ready = !outN_valid || outN_ready of the selected channel.
  - For sel 11: in_ready = 1.
- Latency: a beat accepted at edge k is visible on outN_valid/outN_data after edge k. That is one cycle, with no combinational path from in_data to outN_data.
- Only the selected channel changes on an input transfer. The other channels are untouched, and their independent output transfers proceed in the same cycle.
- Illegal select (11) with in_valid=1:
  - The beat is accepted and discarded.
  - err=1 for the following cycle (registered).
  - drop_cnt increments, saturating at 2^CNT_W-1. At saturation it holds, and err still pulses.
- outN_data holds its last value while outN_valid=0. The consumer must ignore it.
- Back-to-back beats to the same stalled channel: the first fills the slot, then in_ready=0 until the consumer takes it. No beat is lost or duplicated.

Decomposition:
- Shared package demux_pkg:
  - Channel-index constants CH0=2'b00, CH1=2'b01, CH2=2'b10, SEL_ILLEGAL=2'b11.
  - Default widths W and CNT_W.
- One natural sub-module: stream_slot, the one-entry valid/data holding register with load/unload logic. It is instantiated three times.
- The top level holds sel decode, in_ready mux and the drop counter.

Test Plan:
- Reset: assert rst mid-run with channel 1 full (0xA5) -> out1_valid=0 and drop_cnt=0 immediately, without a clock edge. After release, the first beat 0x11 to sel 00 appears on out0 one cycle later.
- Routing: beats 0x01, 0x02, 0x03 with sel 00, 01, 10, all readys=1 -> out0_data=0x01, out1_data=0x02, out2_data=0x03, each valid for exactly one cycle, one cycle after acceptance.
- Backpressure: out2_ready=0, two beats 0x40, 0x41 to sel 10 -> 0x40 held, in_ready=0 on the second beat. Raising out2_ready -> 0x40 then 0x41, no loss or duplication.
- Throughput: out0_ready=1, ten consecutive beats 0x00..0x09 to sel 00 -> in_ready stays 1 and out0 shows all ten on consecutive cycles.
- Illegal select: three beats with sel 11 -> in_ready=1, no outN_valid, err pulses three times, drop_cnt=3. With CNT_W=2 and five drops -> drop_cnt saturates at 3.
- Independence: channel 0 stalled and full, beat to sel 01 -> accepted immediately, out1_valid next cycle, channel 0 unchanged.
